op_counter: RTL and testbench
=============================

# op_counter

Parametrised multi-mode counter/shifter, the next generation of the team's 12-bit decrement/shift counter. Adds configurable width, an encoded operation select with increment and decrement by a runtime step, wrap or saturate arithmetic, rotate and arithmetic-shift modes with parametrised amounts, an external load path, a terminal-count pulse and a one-shot mode with a small control FSM. It sits in the same datapath slot as the existing counter and feeds the display/monitor logic through `data`.

## Interface
- `WIDTH`, 12: counter width, at least 4.
- `INIT`, 0: value loaded by `set`, WIDTH bits.
- `SHR_AMT`, 1: right rotate/shift distance, 1..WIDTH-1.
- `SHL_AMT`, 2: left rotate distance, 1..WIDTH-1.
- `o_clk`, in, 1: single clock; all state updates on rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `pause`, in, 1: 1 freezes all state; 0 means active.
- `set`, in, 1: load `INIT`.
- `load`, in, 1: load `load_data`.
- `load_data`, in, WIDTH: external load value.
- `op`, in, 3: `op_e` operation select.
- `step`, in, WIDTH: INC/DEC magnitude.
- `sat_en`, in, 1: 1 saturates INC/DEC; 0 wraps.
- `oneshot`, in, 1: 1 stops counting at zero on DEC.
- `data`, out, WIDTH: counter value, registered.
- `tc`, out, 1: terminal-count pulse, registered.
- `done`, out, 1: high while the FSM is in DONE.

## Operation
- `op_e` encodings:
  - OP_HOLD=0: data unchanged.
  - OP_INC=1: data + step.
  - OP_DEC=2: data - step.
  - OP_ROR=3: rotate right by SHR_AMT.
  - OP_ROL=4: rotate left by SHL_AMT.
  - OP_SAR=5: arithmetic right shift by SHR_AMT, MSB replicated.
  - Codes 6 and 7 behave as HOLD.
- Priority, highest first: reset, pause, set, load, op. If `set` and `load` are both high, `set` wins.
- FSM states are RUN and DONE. Reset enters RUN.
  - RUN to DONE: a DEC in one-shot mode whose result is at or below zero.
  - DONE to RUN: only `set` or `load`. All `op` values are ignored in DONE.
  - Pause holds the current state.
- Arithmetic uses a WIDTH+1-bit sum/difference.
- INC carry-out means overflow:
  - With `sat_en`=1, data becomes all-ones.
  - Otherwise data takes the low WIDTH bits.
  - `tc` is asserted in either case.
- DEC borrow means underflow:
  - With `sat_en`=1, data becomes 0.
  - Otherwise data wraps.
  - `tc` is asserted in either case.
- One-shot DEC:
  - Always saturates at 0, regardless of `sat_en`.
  - If the result is 0, whether exact or after underflow: `tc`=1 and the FSM enters DONE.
- A step of 0 leaves data unchanged and never raises `tc`.
- Rotates and shifts never raise `tc`.
- `tc` is 0 on every cycle with no qualifying event, including pause, set and load cycles.
- Reset values: data=0, tc=0, done=0, state RUN.

## Timing
- All outputs are registered. The effect of inputs sampled at edge N is visible after edge N; there is no combinational input-to-output path.
- `tc` is a single-cycle pulse aligned with the `data` value that caused it.
- `done` rises together with that `tc` pulse. It falls on the edge where `set` or `load` is accepted.
- Pause is honoured on the same edge it is sampled. Releasing it resumes on the next edge with no lost or duplicated operation.
- Reset asserted mid-operation forces the reset values immediately, asynchronously. Deassertion is assumed synchronised upstream. The first operation executes on the first edge with `reset`=1.

## Structure
- `counter_pkg` holds:
  - the `op_e` enum (3-bit);
  - the `state_e` enum (RUN, DONE);
  - shared width-checking constants.
- Optional sub-module `op_counter_alu`: purely combinational next-value and flag logic. Inputs are data, op, step, sat_en and oneshot. Outputs are next_data, tc_next and hit_zero.
- The top level holds the FSM, the priority mux and the registers.
- Parameter legality (SHR_AMT/SHL_AMT in range) is checked with elaboration-time assertions.

## Test plan
All scenarios use WIDTH=12.
1. Reset then `set` with INIT=12'h00A, then 3 cycles of OP_DEC with step=1 → data 009, 008, 007; tc stays 0.
2. data=12'hFFE, OP_INC, step=3:
   - sat_en=0 → data=12'h001, tc pulses 1 cycle.
   - Repeat with sat_en=1 → data=12'hFFF, tc pulses.
3. data=12'h801 and OP_ROL (SHL_AMT=2) → 12'h006. From 12'h801, OP_ROR → 12'hC00. From 12'h801, OP_SAR → 12'hC00. tc is 0 throughout.
4. `oneshot`=1, data=12'h005, OP_DEC with step=2 → data 003, 001, 000:
   - On the 000 edge, tc=1 and done=1.
   - Further DEC cycles hold 000 with tc=0.
   - `load` of 12'h010 → done=0 and data=010.
5. During an INC run, `pause`=1 for 4 cycles → data, tc and state are frozen. On release, counting resumes with the next step. `set` and `load` asserted during the pause are ignored.
6. Assert `reset` low mid-run between clock edges → data=0 and done=0 immediately, without waiting for an edge. `set` and `load` high on the same edge → INIT is loaded.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and parameter checks for the op_counter family.
// Operation encodings, control states and width helpers.
package counter_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_INC  = 3'd1,
    OP_DEC  = 3'd2,
    OP_ROR  = 3'd3,
    OP_ROL  = 3'd4,
    OP_SAR  = 3'd5
  } op_e;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_e;

  localparam int MIN_WIDTH = 4;

  function automatic bit amt_ok(input int amt, input int width);
    return (amt >= 1) && (amt <= width - 1);
  endfunction

endpackage

// File: rtl/op_counter_alu.sv
// Combinational next-value logic for op_counter.
// Computes the candidate value plus terminal-count and one-shot flags.
module op_counter_alu
  import counter_pkg::*;
#(
  parameter int WIDTH   = 12,
  parameter int SHR_AMT = 1,
  parameter int SHL_AMT = 2
) (
  input  logic [WIDTH-1:0] data,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] step,
  input  logic             sat_en,
  input  logic             oneshot,
  output logic [WIDTH-1:0] next_data,
  output logic             tc_next,
  output logic             hit_zero
);

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] dbl;
  logic               step_zero;

  assign sum       = {1'b0, data} + {1'b0, step};
  assign diff      = {1'b0, data} - {1'b0, step};
  assign dbl       = {data, data};
  assign step_zero = (step == '0);

  always_comb begin
    next_data = data;
    tc_next   = 1'b0;
    hit_zero  = 1'b0;
    case (op_e'(op))
      OP_INC: begin
        if (!step_zero) begin
          next_data = sum[WIDTH-1:0];
          if (sum[WIDTH]) begin
            tc_next = 1'b1;
            if (sat_en) next_data = '1;
          end
        end
      end
      OP_DEC: begin
        if (!step_zero) begin
          next_data = diff[WIDTH-1:0];
          // One-shot clamps at zero whether it lands exactly or borrows
          if (oneshot) begin
            if (diff[WIDTH] || diff[WIDTH-1:0] == '0) begin
              next_data = '0;
              tc_next   = 1'b1;
              hit_zero  = 1'b1;
            end
          end else if (diff[WIDTH]) begin
            tc_next = 1'b1;
            if (sat_en) next_data = '0;
          end
        end
      end
      OP_ROR:  next_data = dbl[SHR_AMT +: WIDTH];
      OP_ROL:  next_data = dbl[WIDTH-SHL_AMT +: WIDTH];
      OP_SAR:  next_data = $signed(data) >>> SHR_AMT;
      default: next_data = data;
    endcase
  end

endmodule

// File: rtl/op_counter.sv
// Multi-mode counter/shifter with load path and one-shot control.
// Holds the RUN/DONE FSM, input priority mux and output registers.
module op_counter
  import counter_pkg::*;
#(
  parameter int               WIDTH   = 12,
  parameter logic [WIDTH-1:0] INIT    = '0,
  parameter int               SHR_AMT = 1,
  parameter int               SHL_AMT = 2
) (
  input  logic             o_clk,
  input  logic             reset,
  input  logic             pause,
  input  logic             set,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] step,
  input  logic             sat_en,
  input  logic             oneshot,
  output logic [WIDTH-1:0] data,
  output logic             tc,
  output logic             done
);

  if (WIDTH < MIN_WIDTH) begin : g_bad_width
    $error("op_counter: WIDTH below minimum");
  end
  if (!amt_ok(SHR_AMT, WIDTH)) begin : g_bad_shr
    $error("op_counter: SHR_AMT out of range");
  end
  if (!amt_ok(SHL_AMT, WIDTH)) begin : g_bad_shl
    $error("op_counter: SHL_AMT out of range");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             tc_q, tc_d;

  logic [WIDTH-1:0] alu_data;
  logic             alu_tc;
  logic             alu_zero;

  op_counter_alu #(
    .WIDTH   (WIDTH),
    .SHR_AMT (SHR_AMT),
    .SHL_AMT (SHL_AMT)
  ) u_alu (
    .data      (data_q),
    .op        (op),
    .step      (step),
    .sat_en    (sat_en),
    .oneshot   (oneshot),
    .next_data (alu_data),
    .tc_next   (alu_tc),
    .hit_zero  (alu_zero)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    tc_d    = 1'b0;
    if (pause) begin
      state_d = state_q;
    end else if (set) begin
      data_d  = INIT;
      state_d = RUN;
    end else if (load) begin
      data_d  = load_data;
      state_d = RUN;
    end else if (state_q == RUN) begin
      data_d = alu_data;
      tc_d   = alu_tc;
      if (alu_zero) state_d = DONE;
    end
  end

  always_ff @(posedge o_clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      data_q  <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      tc_q    <= tc_d;
    end
  end

  assign data = data_q;
  assign tc   = tc_q;
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_op_counter.sv
// Directed scoreboard bench for op_counter at WIDTH=12.
// Expected values are queued at drive time and checked after the edge.
module tb_op_counter;
  import counter_pkg::*;

  logic        o_clk = 1'b0;
  logic        reset = 1'b0;
  logic        pause = 1'b0;
  logic        set = 1'b0;
  logic        load = 1'b0;
  logic [11:0] load_data = '0;
  logic [2:0]  op = 3'd0;
  logic [11:0] step = '0;
  logic        sat_en = 1'b0;
  logic        oneshot = 1'b0;
  logic [11:0] data;
  logic        tc;
  logic        done;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string       tag;
    logic [11:0] d;
    logic        t;
    logic        dn;
  } exp_t;

  exp_t sb[$];

  op_counter #(
    .WIDTH   (12),
    .INIT    (12'h00A),
    .SHR_AMT (1),
    .SHL_AMT (2)
  ) dut (
    .o_clk     (o_clk),
    .reset     (reset),
    .pause     (pause),
    .set       (set),
    .load      (load),
    .load_data (load_data),
    .op        (op),
    .step      (step),
    .sat_en    (sat_en),
    .oneshot   (oneshot),
    .data      (data),
    .tc        (tc),
    .done      (done)
  );

  always #5 o_clk = ~o_clk;

  task automatic chk(input string tag, input logic [11:0] obs,
                     input logic [11:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_sb();
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL scoreboard: observed empty expected entry");
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".data"}, data, e.d);
    chk({e.tag, ".tc"}, {11'd0, tc}, {11'd0, e.t});
    chk({e.tag, ".done"}, {11'd0, done}, {11'd0, e.dn});
  endtask

  task automatic cyc(input string tag, input logic s, input logic l,
                     input logic [11:0] ld, input op_e o,
                     input logic [11:0] st, input logic [11:0] ed,
                     input logic et, input logic edn);
    exp_t e;
    @(negedge o_clk);
    set = s;
    load = l;
    load_data = ld;
    op = o;
    step = st;
    e.tag = tag;
    e.d = ed;
    e.t = et;
    e.dn = edn;
    sb.push_back(e);
    @(posedge o_clk);
    #1;
    check_sb();
  endtask

  initial begin
    #12;
    chk("rst.data", data, 12'h000);
    chk("rst.tc", {11'd0, tc}, 12'h000);
    chk("rst.done", {11'd0, done}, 12'h000);
    @(negedge o_clk);
    reset = 1'b1;

    // Scenario 1: set then plain decrement
    cyc("set", 1, 0, 0, OP_HOLD, 0, 12'h00A, 0, 0);
    cyc("dec1", 0, 0, 0, OP_DEC, 1, 12'h009, 0, 0);
    cyc("dec2", 0, 0, 0, OP_DEC, 1, 12'h008, 0, 0);
    cyc("dec3", 0, 0, 0, OP_DEC, 1, 12'h007, 0, 0);

    // Scenario 2: increment overflow, wrap then saturate
    cyc("ldFFE", 0, 1, 12'hFFE, OP_INC, 3, 12'hFFE, 0, 0);
    cyc("incwrap", 0, 0, 0, OP_INC, 3, 12'h001, 1, 0);
    cyc("hold", 0, 0, 0, OP_HOLD, 3, 12'h001, 0, 0);
    sat_en = 1'b1;
    cyc("ldFFE2", 0, 1, 12'hFFE, OP_HOLD, 3, 12'hFFE, 0, 0);
    cyc("incsat", 0, 0, 0, OP_INC, 3, 12'hFFF, 1, 0);
    cyc("incsat2", 0, 0, 0, OP_INC, 3, 12'hFFF, 1, 0);
    cyc("step0", 0, 0, 0, OP_INC, 0, 12'hFFF, 0, 0);

    // Decrement underflow: saturate then wrap
    cyc("ld001", 0, 1, 12'h001, OP_HOLD, 0, 12'h001, 0, 0);
    cyc("decsat", 0, 0, 0, OP_DEC, 2, 12'h000, 1, 0);
    sat_en = 1'b0;
    cyc("decwrap", 0, 0, 0, OP_DEC, 2, 12'hFFE, 1, 0);

    // Scenario 3: rotates and arithmetic shift
    cyc("ld801a", 0, 1, 12'h801, OP_HOLD, 0, 12'h801, 0, 0);
    cyc("rol", 0, 0, 0, OP_ROL, 0, 12'h006, 0, 0);
    cyc("ld801b", 0, 1, 12'h801, OP_HOLD, 0, 12'h801, 0, 0);
    cyc("ror", 0, 0, 0, OP_ROR, 0, 12'hC00, 0, 0);
    cyc("ld801c", 0, 1, 12'h801, OP_HOLD, 0, 12'h801, 0, 0);
    cyc("sar", 0, 0, 0, OP_SAR, 0, 12'hC00, 0, 0);
    cyc("op6", 0, 0, 0, op_e'(3'd6), 0, 12'hC00, 0, 0);
    cyc("sar2", 0, 0, 0, OP_SAR, 0, 12'hE00, 0, 0);

    // Scenario 4: one-shot decrement down to done
    oneshot = 1'b1;
    cyc("ld005", 0, 1, 12'h005, OP_HOLD, 0, 12'h005, 0, 0);
    cyc("os1", 0, 0, 0, OP_DEC, 2, 12'h003, 0, 0);
    cyc("os2", 0, 0, 0, OP_DEC, 2, 12'h001, 0, 0);
    cyc("os3", 0, 0, 0, OP_DEC, 2, 12'h000, 1, 1);
    cyc("os4", 0, 0, 0, OP_DEC, 2, 12'h000, 0, 1);
    cyc("osinc", 0, 0, 0, OP_INC, 2, 12'h000, 0, 1);
    cyc("ld010", 0, 1, 12'h010, OP_DEC, 2, 12'h010, 0, 0);
    oneshot = 1'b0;

    // Scenario 5: pause freezes, set/load ignored
    cyc("ld000", 0, 1, 12'h000, OP_HOLD, 0, 12'h000, 0, 0);
    cyc("inc1", 0, 0, 0, OP_INC, 1, 12'h001, 0, 0);
    cyc("inc2", 0, 0, 0, OP_INC, 1, 12'h002, 0, 0);
    pause = 1'b1;
    cyc("p1", 0, 0, 0, OP_INC, 1, 12'h002, 0, 0);
    cyc("p2", 1, 0, 0, OP_INC, 1, 12'h002, 0, 0);
    cyc("p3", 0, 1, 12'h555, OP_INC, 1, 12'h002, 0, 0);
    cyc("p4", 1, 1, 12'h555, OP_INC, 1, 12'h002, 0, 0);
    pause = 1'b0;
    cyc("resume", 0, 0, 0, OP_INC, 1, 12'h003, 0, 0);

    // Scenario 6: async reset from DONE, then set beats load
    oneshot = 1'b1;
    cyc("os5", 0, 0, 0, OP_DEC, 5, 12'h000, 1, 1);
    @(negedge o_clk);
    #2;
    reset = 1'b0;
    #1;
    chk("arst.data", data, 12'h000);
    chk("arst.done", {11'd0, done}, 12'h000);
    oneshot = 1'b0;
    @(negedge o_clk);
    reset = 1'b1;
    cyc("setwin", 1, 1, 12'h123, OP_INC, 1, 12'h00A, 0, 0);
    cyc("after", 0, 0, 0, OP_INC, 1, 12'h00B, 0, 0);

    chk("sb.empty", 12'(sb.size()), 12'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
